keypad_entry_ctrl: RTL and testbench

//  Sequences the 10-key priority encoder path for microwave time entry.
//  - Synchronises and debounces the raw keypad.
//  - Emits one strobe per accepted press.
//  - Shifts digits into a 4-digit BCD MM:SS entry register.
//  - Hands the entry to the cook timer with a req/ack load handshake.

---
 rtl/keypad_entry_if.sv | 59 +++++
 rtl/keypad_entry_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// ---------------------------------------------------------------------------
// keypad_entry_if
//   Bundles the keypad-entry controller's control inputs and status outputs
//   so the controller and its user connect through one port.
//
//   Signals
//     enablen     active-low entry enable
//     keypad[9:0] raw key lines, bit i = digit i (asynchronous to clk)
//     start       one-cycle request to load the entry into the cook timer
//     clear       one-cycle request to zero the entry
//     load_ack    cook timer has taken time_out
//     key_code    last accepted digit, 0..9
//     key_strobe  one-cycle pulse per accepted digit
//     time_out    {min_tens, min_ones, sec_tens, sec_ones}, BCD
//     digit_cnt   digits entered, 0..4
//     load_req    time_out is valid and held for the timer
//
//   Modports
//     slave  : the controller (drives the status outputs)
//     master : the user / timer side (drives the control inputs)
// ---------------------------------------------------------------------------
interface keypad_entry_if;
  logic        enablen;
  logic [9:0]  keypad;
  logic        start;
  logic        clear;
  logic        load_ack;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic [15:0] time_out;
  logic [2:0]  digit_cnt;
  logic        load_req;

  modport slave (
    input  enablen,
    input  keypad,
    input  start,
    input  clear,
    input  load_ack,
    output key_code,
    output key_strobe,
    output time_out,
    output digit_cnt,
    output load_req
  );

  modport master (
    output enablen,
    output keypad,
    output start,
    output clear,
    output load_ack,
    input  key_code,
    input  key_strobe,
    input  time_out,
    input  digit_cnt,
    input  load_req
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_entry_ctrl
//   Microwave time-entry front end for a 10-key keypad.
//     - two-flop synchroniser on the raw key lines
//     - priority encoder (highest pressed digit wins)
//     - debounce FSM: DEBOUNCE_CYCLES stable samples for press and release
//     - one key_strobe per accepted press
//     - 4-digit BCD MM:SS shift-in entry register
//     - req/ack load handshake towards the cook timer
//
//   Parameters
//     DEBOUNCE_CYCLES  stable cycles for press and release (2..255)
//
//   Ports
//     clk     system clock, rising edge
//     resetn  asynchronous active-low reset
//     bus     keypad_entry_if.slave (see interface file for signal list)
//
//   Build option
//     KEYPAD_SEC_CLAMP_EN  when defined, a seconds-tens digit above 5 is
//                          replaced by 5,9 in the seconds field at the moment
//                          the entry is handed to the timer.
// ---------------------------------------------------------------------------
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           resetn,
  keypad_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Synchroniser: two flops per key line
  // -------------------------------------------------------------------------
  logic [9:0] sync1_reg;
  logic [9:0] sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_sync
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= bus.keypad[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Priority encoder: ascending scan, so the highest set bit is kept
  // -------------------------------------------------------------------------
  logic [3:0] code;
  logic       any_key;

  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (sync2_reg[i]) code = 4'(i);
    end
  end

  assign any_key = |sync2_reg;

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] cand_reg, cand_next;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      cand_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    if (bus.enablen) begin
      state_next = ST_IDLE;
      cnt_next   = 8'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_key) begin
            state_next = ST_DEBOUNCE;
            cnt_next   = 8'd1;
            cand_next  = code;
          end
        end
        ST_DEBOUNCE: begin
          if (!any_key) begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
          end else if (code != cand_reg) begin
            // A different key restarts the stability window on that key.
            cand_next = code;
            cnt_next  = 8'd1;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = ST_PRESSED;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        ST_PRESSED: begin
          state_next = ST_RELEASE;
          cnt_next   = 8'd0;
        end
        ST_RELEASE: begin
          if (any_key) begin
            cnt_next = 8'd0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

  // Output logic: the press is accepted on the edge that enters PRESSED,
  // which puts the registered strobe high exactly during the PRESSED cycle.
  logic accept;
  logic take_digit;
  logic strobe_next;
  logic load_req_reg;

  always_comb begin
    accept      = (state_reg == ST_DEBOUNCE) && (state_next == ST_PRESSED);
    take_digit  = accept && !load_req_reg;
    strobe_next = take_digit;
  end

  // -------------------------------------------------------------------------
  // Entry register and load handshake
  // -------------------------------------------------------------------------
  logic [15:0] time_out_reg;
  logic [2:0]  digit_cnt_reg;
  logic [3:0]  key_code_reg;
  logic        key_strobe_reg;
  logic [15:0] load_value;

`ifdef KEYPAD_SEC_CLAMP_EN
  // Seconds tens above 5 is not a valid time; saturate the seconds field.
  assign load_value = (time_out_reg[7:4] > 4'd5) ? {time_out_reg[15:8], 8'h59}
                                                 : time_out_reg;
`else
  assign load_value = time_out_reg;
`endif

  // Priority while not loading: clear, then start, then digit shift-in.
  // key_code and the strobe follow any accepted press even when a clear or
  // start on the same edge keeps the digit out of the entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      time_out_reg   <= 16'd0;
      digit_cnt_reg  <= 3'd0;
      key_code_reg   <= 4'd0;
      key_strobe_reg <= 1'b0;
      load_req_reg   <= 1'b0;
    end else begin
      key_strobe_reg <= strobe_next;
      if (take_digit) begin
        key_code_reg <= cand_reg;
      end
      if (load_req_reg) begin
        // Entry is frozen; only the timer's acknowledge can release it.
        if (bus.load_ack) begin
          load_req_reg  <= 1'b0;
          time_out_reg  <= 16'd0;
          digit_cnt_reg <= 3'd0;
        end
      end else if (!bus.enablen) begin
        if (bus.clear) begin
          time_out_reg  <= 16'd0;
          digit_cnt_reg <= 3'd0;
        end else if (bus.start && (digit_cnt_reg != 3'd0)) begin
          load_req_reg <= 1'b1;
          time_out_reg <= load_value;
        end else if (take_digit && (digit_cnt_reg < 3'd4)) begin
          time_out_reg  <= {time_out_reg[11:0], cand_reg};
          digit_cnt_reg <= digit_cnt_reg + 3'd1;
        end
      end
    end
  end

  assign bus.key_code   = key_code_reg;
  assign bus.key_strobe = key_strobe_reg;
  assign bus.time_out   = time_out_reg;
  assign bus.digit_cnt  = digit_cnt_reg;
  assign bus.load_req   = load_req_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;
  localparam int D = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_if bus();

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: run-length view of the synchronised key samples plus a
  // digit queue for the entry.
  // -------------------------------------------------------------------------
  logic [9:0]  m_s1 = '0, m_s2 = '0;
  int          m_phase = 0;       // 0 seeking press, 1 pressed cycle, 2 awaiting release
  int          m_run = 0;         // consecutive samples of m_cand (0 = none)
  int          m_zero = 0;        // consecutive released samples
  int          m_cand = 0;
  int          m_dig[$];
  bit          m_load_req = 0;
  logic [15:0] m_held = '0;
  int          m_code = 0;
  bit          m_strobe = 0;

  function automatic int prio(input logic [9:0] k);
    for (int i = 9; i >= 0; i--) if (k[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] pack_entry();
    logic [15:0] v;
    v = '0;
    foreach (m_dig[i]) v = {v[11:0], 4'(m_dig[i])};
    return v;
  endfunction

  initial begin : model
    int  c;
    bit  any, acc, lr;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_s1 = '0; m_s2 = '0; m_phase = 0; m_run = 0; m_zero = 0; m_cand = 0;
        m_dig.delete(); m_load_req = 0; m_held = '0; m_code = 0; m_strobe = 0;
      end else begin
        c   = prio(m_s2);
        any = |m_s2;
        acc = 0;
        lr  = m_load_req;
        if (bus.enablen) begin
          m_phase = 0; m_run = 0;
        end else if (m_phase == 0) begin
          if (!any) m_run = 0;
          else if (m_run > 0 && c == m_cand) begin
            m_run++;
            if (m_run == D) begin acc = 1; m_phase = 1; end
          end else begin
            m_cand = c; m_run = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2; m_zero = 0;
        end else begin
          if (any) m_zero = 0;
          else begin
            m_zero++;
            if (m_zero == D) begin m_phase = 0; m_run = 0; end
          end
        end
        m_strobe = acc && !lr;
        if (acc && !lr) m_code = m_cand;
        if (lr) begin
          if (bus.load_ack) begin m_load_req = 0; m_dig.delete(); end
        end else if (!bus.enablen) begin
          if (bus.clear) m_dig.delete();
          else if (bus.start && m_dig.size() > 0) begin
            m_load_req = 1;
            m_held = pack_entry();
`ifdef KEYPAD_SEC_CLAMP_EN
            if (m_held[7:4] > 4'd5) m_held[7:0] = 8'h59;
`endif
          end else if (acc && m_dig.size() < 4) m_dig.push_back(m_cand);
        end
        m_s2 = m_s1;
        m_s1 = bus.keypad;
      end
    end
  end

  // Continuous comparison against the model
  initial begin : monitor
    logic [15:0] exp_t;
    forever begin
      @(negedge clk);
      if (resetn) begin
        exp_t = m_load_req ? m_held : pack_entry();
        check("model", {bus.key_strobe, bus.key_code, bus.time_out, bus.digit_cnt, bus.load_req},
              {m_strobe, 4'(m_code), exp_t, 3'(m_dig.size()), m_load_req});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic press_key(input logic [9:0] k, input int hold, output int strobes);
    strobes = 0;
    @(posedge clk); #1 bus.keypad = k;
    repeat (hold) begin @(posedge clk); #2; if (bus.key_strobe) strobes++; end
    bus.keypad = '0;
    repeat (D + 5) begin @(posedge clk); #2; if (bus.key_strobe) strobes++; end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 bus.clear = 1'b1;
    @(posedge clk); #1 bus.clear = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 bus.load_ack = 1'b1;
    @(posedge clk); #1 bus.load_ack = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check(name, {bus.key_strobe, bus.key_code, bus.time_out, bus.digit_cnt, bus.load_req}, 32'd0);
  endtask

  typedef struct {
    logic [9:0]  keys;
    logic [3:0]  exp_code;
    logic [15:0] exp_time;
    logic [2:0]  exp_cnt;
    bit          clr_after;
  } vec_t;

  vec_t vecs[6];

  initial begin : stim
    int s;
    int lr_cycles;
    int hold_left, en_left, r;
    logic [15:0] exp5;

    vecs[0] = '{10'h041, 4'd6, 16'h0006, 3'd1, 1'b1};
    vecs[1] = '{10'h002, 4'd1, 16'h0001, 3'd1, 1'b0};
    vecs[2] = '{10'h004, 4'd2, 16'h0012, 3'd2, 1'b0};
    vecs[3] = '{10'h008, 4'd3, 16'h0123, 3'd3, 1'b0};
    vecs[4] = '{10'h010, 4'd4, 16'h1234, 3'd4, 1'b0};
    vecs[5] = '{10'h020, 4'd5, 16'h1234, 3'd4, 1'b0};

    bus.enablen = 1'b0; bus.keypad = '0; bus.start = 1'b0;
    bus.clear = 1'b0; bus.load_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_zero("reset_state");
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // 1: exact latency of a steady press
    @(posedge clk); #1 bus.keypad = 10'h008;
    begin
      logic [9:0] hist;
      hist = '0;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #2 hist[i] = bus.key_strobe; end
      check("t1_strobe_timing", 32'(hist), 32'h20);
    end
    check("t1_code", 32'(bus.key_code), 32'd3);
    check("t1_time", 32'(bus.time_out), 32'h0003);
    bus.keypad = '0;
    repeat (D + 5) @(posedge clk);

    // 2: bouncing contact
    pulse_clear();
    s = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bus.keypad = 10'h008;
      repeat (2) begin @(posedge clk); #1; if (bus.key_strobe) s++; end
      bus.keypad = 10'h000;
      repeat (2) begin @(posedge clk); #1; if (bus.key_strobe) s++; end
    end
    check("t2_bounce_strobes", 32'(s), 32'd0);
    press_key(10'h008, D + 4, s);
    check("t2_hold_strobes", 32'(s), 32'd1);
    check("t2_cnt", 32'(bus.digit_cnt), 32'd1);
    check("t2_time", 32'(bus.time_out), 32'h0003);

    // 3: table of presses
    pulse_clear();
    foreach (vecs[i]) begin
      press_key(vecs[i].keys, D + 4, s);
      check($sformatf("t3_strobes[%0d]", i), 32'(s), 32'd1);
      check($sformatf("t3_code[%0d]", i), 32'(bus.key_code), 32'(vecs[i].exp_code));
      check($sformatf("t3_time[%0d]", i), 32'(bus.time_out), 32'(vecs[i].exp_time));
      check($sformatf("t3_cnt[%0d]", i), 32'(bus.digit_cnt), 32'(vecs[i].exp_cnt));
      if (vecs[i].clr_after) pulse_clear();
    end

    // 4: handshake with ack delayed, key press and clear in the window
    pulse_clear();
    press_key(10'h002, D + 4, s);
    press_key(10'h008, D + 4, s);
    press_key(10'h001, D + 4, s);
    check("t4_entry", 32'(bus.time_out), 32'h0130);
    lr_cycles = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.keypad = 10'h008;
    #1 lr_cycles += int'(bus.load_req); check("t4_frozen0", 32'(bus.time_out), 32'h0130);
    @(posedge clk); #1 bus.clear = 1'b1;
    #1 lr_cycles += int'(bus.load_req); check("t4_frozen1", 32'(bus.time_out), 32'h0130);
    @(posedge clk); #1 bus.clear = 1'b0;
    #1 lr_cycles += int'(bus.load_req); check("t4_frozen2", 32'(bus.time_out), 32'h0130);
    @(posedge clk); #1 bus.keypad = '0; bus.load_ack = 1'b1;
    #1 lr_cycles += int'(bus.load_req); check("t4_frozen3", 32'(bus.time_out), 32'h0130);
    @(posedge clk); #1 bus.load_ack = 1'b0;
    #1 lr_cycles += int'(bus.load_req);
    check("t4_lr_cycles", 32'(lr_cycles), 32'd4);
    check("t4_after_time", 32'(bus.time_out), 32'h0);
    check("t4_after_cnt", 32'(bus.digit_cnt), 32'd0);
    repeat (D + 5) @(posedge clk);
    pulse_start();
    #1 check("t4_empty_start", 32'(bus.load_req), 32'd0);

    // 5: seconds clamp option, and press ignored while loading
    pulse_clear();
    press_key(10'h001, D + 4, s);
    press_key(10'h002, D + 4, s);
    press_key(10'h080, D + 4, s);
    press_key(10'h020, D + 4, s);
    check("t5_entry", 32'(bus.time_out), 32'h0175);
    pulse_start();
`ifdef KEYPAD_SEC_CLAMP_EN
    exp5 = 16'h0159;
`else
    exp5 = 16'h0175;
`endif
    #1 check("t5_load_req", 32'(bus.load_req), 32'd1);
    check("t5_load_time", 32'(bus.time_out), 32'(exp5));
    press_key(10'h200, D + 4, s);
    check("t5_busy_strobes", 32'(s), 32'd0);
    check("t5_busy_time", 32'(bus.time_out), 32'(exp5));
    pulse_ack();
    #1 check("t5_acked", 32'({bus.load_req, bus.digit_cnt}), 32'd0);

    // enablen high: no strobes, entry held
    pulse_clear();
    press_key(10'h010, D + 4, s);
    @(posedge clk); #1 bus.enablen = 1'b1;
    press_key(10'h020, D + 4, s);
    check("en_strobes", 32'(s), 32'd0);
    check("en_time", 32'(bus.time_out), 32'h0004);
    @(posedge clk); #1 bus.enablen = 1'b0;

    // 6: reset during RELEASE and during load_req
    @(posedge clk); #1 bus.keypad = 10'h020;
    repeat (D + 4) @(posedge clk);
    #1 bus.keypad = '0;
    repeat (2) @(posedge clk);
    #3 resetn = 1'b0;
    #1 check_zero("t6_reset_release");
    @(posedge clk); #1 resetn = 1'b1;
    press_key(10'h002, D + 4, s);
    pulse_start();
    #1 check("t6_lr_before", 32'(bus.load_req), 32'd1);
    #2 resetn = 1'b0;
    #1 check_zero("t6_reset_load");
    @(posedge clk); #1 resetn = 1'b1;
    press_key(10'h080, D + 4, s);
    check("t6_new_strobes", 32'(s), 32'd1);
    check("t6_new_code", 32'(bus.key_code), 32'd7);
    check("t6_new_time", 32'(bus.time_out), 32'h0007);

    // Random stimulus, checked by the model monitor
    hold_left = 0; en_left = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (n == 1500) resetn = 1'b0;
      if (n == 1503) resetn = 1'b1;
      if (hold_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) bus.keypad = '0;
        else if (r < 9) bus.keypad = 10'b1 << $urandom_range(0, 9);
        else bus.keypad = 10'($urandom_range(1, 1023));
        hold_left = $urandom_range(1, 12);
      end else hold_left--;
      bus.start    = ($urandom_range(0, 29) == 0);
      bus.clear    = ($urandom_range(0, 59) == 0);
      bus.load_ack = ($urandom_range(0, 3) == 0);
      if (en_left > 0) begin
        en_left--;
        if (en_left == 0) bus.enablen = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        bus.enablen = 1'b1;
        en_left = $urandom_range(1, 20);
      end
    end
    bus.keypad = '0; bus.start = 1'b0; bus.clear = 1'b0;
    bus.load_ack = 1'b0; bus.enablen = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
